// File: rtl/tshx_gearbox_pkg.sv
// Shared constants, types and elaboration helpers for the tristate-control gearbox.
// Imported by the interface, the lane slice and the top level.
package tshx_pkg;

  localparam int MAX_DLY = 3;
  localparam int DLY_W   = 2;

  typedef logic [DLY_W-1:0] dly_t;

  function automatic bit ratio_legal(input int ratio);
    return (ratio == 2) || (ratio == 4);
  endfunction

  // Anything other than "RESET" idles high (high-Z) so a mistyped value fails safe
  function automatic logic reset_bit(input string regset);
    return (regset == "RESET") ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/tshx_gearbox_if.sv
// Parallel-word / serial-output bundle between the write-path controller and the gearbox.
// The controller side uses the master modport; the gearbox uses slave.
interface tshx_gearbox_if #(
  parameter int LANES = 1,
  parameter int RATIO = 2
);

  logic [LANES*RATIO-1:0] t_in;
  logic                   load;
  logic                   sync;
  tshx_pkg::dly_t         dly_sel;
  logic [LANES-1:0]       q;

  modport master (
    output t_in,
    output sync,
    output dly_sel,
    input  load,
    input  q
  );

  modport slave (
    input  t_in,
    input  sync,
    input  dly_sel,
    output load,
    output q
  );

endinterface

// File: rtl/tshx_gearbox_lane.sv
// One tristate lane: parallel-load shift register, 3-deep delay line and delay tap mux.
// Capture timing and the effective delay come from the shared top-level control.
module tshx_lane
  import tshx_pkg::*;
#(
  parameter int   RATIO   = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic             eclk_i,
  input  logic             rstb_i,
  input  logic             capture_i,
  input  logic [RATIO-1:0] word_i,
  input  dly_t             dly_i,
  output logic             q_o
);

  logic [RATIO-1:0]   sreg_q, sreg_d;
  logic [MAX_DLY-1:0] dlyLine_q, dlyLine_d;
  logic               qRaw;

  assign qRaw = sreg_q[0];

  // Top bit refills from itself so the last transmitted bit holds until the next capture
  always_comb begin
    sreg_d    = {sreg_q[RATIO-1], sreg_q[RATIO-1:1]};
    dlyLine_d = {dlyLine_q[MAX_DLY-2:0], qRaw};
    if (capture_i) begin
      sreg_d = word_i;
    end
  end

  always_ff @(posedge eclk_i) begin
    if (rstb_i) begin
      sreg_q    <= {RATIO{RST_VAL}};
      dlyLine_q <= {MAX_DLY{RST_VAL}};
    end else begin
      sreg_q    <= sreg_d;
      dlyLine_q <= dlyLine_d;
    end
  end

  always_comb begin
    q_o = qRaw;
    case (dly_i)
      2'd1:    q_o = dlyLine_q[0];
      2'd2:    q_o = dlyLine_q[1];
      2'd3:    q_o = dlyLine_q[2];
      default: q_o = qRaw;
    endcase
  end

endmodule

// File: rtl/tshx_gearbox.sv
// Tristate-control gearbox top: phase counter, load strobe, word-aligned delay register
// and per-lane slicing of the parallel word.
module tshx_gearbox
  import tshx_pkg::*;
#(
  parameter int    LANES  = 1,
  parameter int    RATIO  = 2,
  parameter string REGSET = "SET"
) (
  input  logic                 eclk_i,
  input  logic                 rstb_i,
  tshx_gearbox_if.slave        bus
);

  localparam int            CW      = $clog2(RATIO);
  localparam logic [CW-1:0] LAST    = CW'(RATIO - 1);
  localparam logic          RST_VAL = reset_bit(REGSET);

  if (!ratio_legal(RATIO)) begin : gBadRatio
    $error("tshx_gearbox: RATIO must be 2 or 4");
  end

  logic [CW-1:0]    cnt_q, cnt_d;
  dly_t             dlyEff_q, dlyEff_d;
  logic             load;
  logic             capture;
  logic [LANES-1:0] q;

  // A sync request cancels the capture so realignment never takes a half-formed word
  assign load    = (cnt_q == LAST) && !rstb_i;
  assign capture = load && !bus.sync;

  always_comb begin
    cnt_d    = cnt_q + CW'(1);
    dlyEff_d = dlyEff_q;
    if (bus.sync || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
    if (capture) begin
      dlyEff_d = bus.dly_sel;
    end
  end

  always_ff @(posedge eclk_i) begin
    if (rstb_i) begin
      cnt_q    <= '0;
      dlyEff_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      dlyEff_q <= dlyEff_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : gLane
    tshx_lane #(
      .RATIO   (RATIO),
      .RST_VAL (RST_VAL)
    ) uLane (
      .eclk_i    (eclk_i),
      .rstb_i    (rstb_i),
      .capture_i (capture),
      .word_i    (bus.t_in[l*RATIO +: RATIO]),
      .dly_i     (dlyEff_q),
      .q_o       (q[l])
    );
  end

  assign bus.load = load;
  assign bus.q    = q;

endmodule

// File: tb/tb_tshx_gearbox.sv
// Directed bench for tshx_gearbox: three configurations (4-lane 2:1 SET, 1-lane 4:1 SET,
// 1-lane 4:1 RESET) exercised one after another from a single stimulus sequence.
module tb_tshx_gearbox;

  logic eclk;
  logic rstbA, rstbB, rstbC;
  int   checks;
  int   errors;

  tshx_gearbox_if #(.LANES(4), .RATIO(2)) busA ();
  tshx_gearbox_if #(.LANES(1), .RATIO(4)) busB ();
  tshx_gearbox_if #(.LANES(1), .RATIO(4)) busC ();

  tshx_gearbox #(.LANES(4), .RATIO(2), .REGSET("SET")) dutA (
    .eclk_i (eclk),
    .rstb_i (rstbA),
    .bus    (busA)
  );

  tshx_gearbox #(.LANES(1), .RATIO(4), .REGSET("SET")) dutB (
    .eclk_i (eclk),
    .rstb_i (rstbB),
    .bus    (busB)
  );

  tshx_gearbox #(.LANES(1), .RATIO(4), .REGSET("RESET")) dutC (
    .eclk_i (eclk),
    .rstb_i (rstbC),
    .bus    (busC)
  );

  initial eclk = 1'b0;
  always #5 eclk = ~eclk;

  // Advance n rising edges, then settle 1 time unit so outputs are sampled off the edge
  task automatic waitEdges(input int n);
    repeat (n) @(posedge eclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstbA = 1'b1;
    rstbB = 1'b1;
    rstbC = 1'b1;
    busA.t_in = '0; busA.sync = 1'b0; busA.dly_sel = 2'd0;
    busB.t_in = '0; busB.sync = 1'b0; busB.dly_sel = 2'd0;
    busC.t_in = '0; busC.sync = 1'b0; busC.dly_sel = 2'd0;

    $display("[TB] config A: 4 lanes, 2:1, SET");
    #1;
    checkOutput("A load before first edge", 32'(busA.load), 32'd0);
    waitEdges(3);
    checkOutput("A q after reset", 32'(busA.q), 32'b1111);
    checkOutput("A load in reset", 32'(busA.load), 32'd0);
    rstbA = 1'b0;
    checkOutput("A load cnt0", 32'(busA.load), 32'd0);
    busA.t_in = 8'b01_10_11_01;
    waitEdges(1);
    checkOutput("A load after edge1", 32'(busA.load), 32'd1);
    waitEdges(1);
    checkOutput("A w1 bit0", 32'(busA.q), 32'b1011);
    checkOutput("A load after edge2", 32'(busA.load), 32'd0);
    waitEdges(1);
    checkOutput("A w1 bit1", 32'(busA.q), 32'b0110);
    checkOutput("A load after edge3", 32'(busA.load), 32'd1);
    busA.t_in = 8'b10_01_00_10;
    waitEdges(1);
    checkOutput("A w2 bit0 gapless", 32'(busA.q), 32'b0100);
    waitEdges(1);
    checkOutput("A w2 bit1", 32'(busA.q), 32'b1001);
    busA.t_in = 8'b00_11_01_10;
    waitEdges(1);
    checkOutput("A w3 bit0", 32'(busA.q), 32'b0110);
    busA.dly_sel = 2'd2;
    busA.t_in    = 8'b11_00_10_01;
    waitEdges(1);
    checkOutput("A w3 bit1 mid-word dly change", 32'(busA.q), 32'b0101);
    waitEdges(1);
    checkOutput("A dly2 edge8 repeat", 32'(busA.q), 32'b0110);
    waitEdges(1);
    checkOutput("A dly2 edge9 repeat", 32'(busA.q), 32'b0101);
    waitEdges(1);
    checkOutput("A w4 bit0 delayed", 32'(busA.q), 32'b1001);
    waitEdges(1);
    checkOutput("A w4 bit1 delayed", 32'(busA.q), 32'b1010);

    $display("[TB] config B: 1 lane, 4:1, SET");
    busB.t_in = 4'b0110;
    checkOutput("B q after reset", 32'(busB.q), 32'd1);
    rstbB = 1'b0;
    waitEdges(3);
    checkOutput("B first load", 32'(busB.load), 32'd1);
    waitEdges(1);
    checkOutput("B bit0", 32'(busB.q), 32'd0);
    busB.t_in = 4'b1110;
    waitEdges(1);
    checkOutput("B bit1", 32'(busB.q), 32'd1);
    waitEdges(1);
    checkOutput("B bit2", 32'(busB.q), 32'd1);
    waitEdges(1);
    checkOutput("B bit3", 32'(busB.q), 32'd0);
    waitEdges(1);
    checkOutput("B w2 bit0", 32'(busB.q), 32'd0);
    busB.t_in = 4'b0000;
    waitEdges(1);
    checkOutput("B w2 bit1", 32'(busB.q), 32'd1);
    checkOutput("B load at cnt1", 32'(busB.load), 32'd0);
    busB.sync = 1'b1;
    waitEdges(1);
    busB.sync = 1'b0;
    checkOutput("B w2 bit2 at sync", 32'(busB.q), 32'd1);
    waitEdges(1);
    checkOutput("B load suppressed 1", 32'(busB.load), 32'd0);
    waitEdges(1);
    checkOutput("B q held after sync", 32'(busB.q), 32'd1);
    checkOutput("B load suppressed 2", 32'(busB.load), 32'd0);
    waitEdges(1);
    checkOutput("B load after sync+3", 32'(busB.load), 32'd1);
    checkOutput("B q still held", 32'(busB.q), 32'd1);
    waitEdges(1);
    checkOutput("B capture after sync", 32'(busB.q), 32'd0);

    $display("[TB] config C: 1 lane, 4:1, RESET");
    checkOutput("C q after reset", 32'(busC.q), 32'd0);
    checkOutput("C load in reset", 32'(busC.load), 32'd0);
    busC.t_in = 4'b0111;
    rstbC = 1'b0;
    waitEdges(3);
    checkOutput("C first load", 32'(busC.load), 32'd1);
    waitEdges(1);
    checkOutput("C bit0", 32'(busC.q), 32'd1);
    waitEdges(1);
    checkOutput("C bit1", 32'(busC.q), 32'd1);
    rstbC = 1'b1;
    waitEdges(1);
    checkOutput("C q after mid-word reset", 32'(busC.q), 32'd0);
    checkOutput("C load in mid-word reset", 32'(busC.load), 32'd0);
    rstbC = 1'b0;
    waitEdges(1);
    checkOutput("C no partial word 1", 32'(busC.q), 32'd0);
    checkOutput("C load after release edge1", 32'(busC.load), 32'd0);
    waitEdges(1);
    checkOutput("C no partial word 2", 32'(busC.q), 32'd0);
    waitEdges(1);
    checkOutput("C load after release edge3", 32'(busC.load), 32'd1);
    waitEdges(1);
    checkOutput("C new word bit0", 32'(busC.q), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
